// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/execute-side signal bundle for the PC and flag sequencer
interface pc_sequencer_if;
    logic        stall;
    logic        halt;
    logic [2:0]  flag_wr;
    logic [2:0]  alu_flags;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        br_reg;
    logic [15:0] br_pc;
    logic [8:0]  br_imm;
    logic [15:0] br_tgt;
    logic [15:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [2:0]  flags;
    logic        taken;
    logic        halted;

    // Pipeline side: decode/execute drive requests, observe the sequencer state
    modport master (
        output stall, halt, flag_wr, alu_flags, br_valid, br_cond, br_reg, br_pc, br_imm, br_tgt,
        input  pc, pc_valid, flush, flags, taken, halted
    );

    // Sequencer side
    modport slave (
        input  stall, halt, flag_wr, alu_flags, br_valid, br_cond, br_reg, br_pc, br_imm, br_tgt,
        output pc, pc_valid, flush, flags, taken, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC/flag sequencer with branch resolve, flush, stall and halt; PC_SEQ_FLAG_FWD_EN enables flag forwarding
module pc_sequencer #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [15:0] RESET_PC     = 16'h0000
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] pc_q;
    logic        pc_valid_q;
    logic        flush_q;
    logic [2:0]  flags_q;
    logic        halted_q;

    logic [2:0]  flags_d;
    logic [2:0]  cond_flags;
    logic        cond_ok;
    logic        redirect_ok;
    logic        taken_w;
    logic [15:0] pc_plus2;
    logic [15:0] br_target;

    // Per-bit merge of ALU flag writes over the architectural register
    assign flags_d = (bus.flag_wr & bus.alu_flags) | (~bus.flag_wr & flags_q);

`ifdef PC_SEQ_FLAG_FWD_EN
    // Branch sees the flags its predecessor is writing this cycle
    assign cond_flags = flags_d;
`else
    // Branch sees committed flags only; decode inserts the bubble
    assign cond_flags = flags_q;
`endif

    // Condition decode, flags ordered V N Z
    always_comb begin
        cond_ok = 1'b0;
        case (bus.br_cond)
            3'b000:  cond_ok = ~cond_flags[0];
            3'b001:  cond_ok = cond_flags[0];
            3'b010:  cond_ok = ~cond_flags[0] & ~cond_flags[1];
            3'b011:  cond_ok = cond_flags[1];
            3'b100:  cond_ok = cond_flags[0] | (~cond_flags[0] & ~cond_flags[1]);
            3'b101:  cond_ok = cond_flags[1] | cond_flags[0];
            3'b110:  cond_ok = cond_flags[2];
            default: cond_ok = 1'b1;
        endcase
    end

    // Branches only resolve while the core is fetching
    assign redirect_ok = (state_q == RUN) || (state_q == FLUSH);
    assign taken_w     = bus.br_valid & cond_ok & redirect_ok;

    // Immediate offset is in words, so shift the sign-extended value by one
    assign br_target = bus.br_reg ? bus.br_tgt
                                  : bus.br_pc + 16'd2 + {{6{bus.br_imm[8]}}, bus.br_imm, 1'b0};
    assign pc_plus2  = pc_q + 16'd2;

    // Sequencer FSM: PC, flush window, halt parking and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            cnt_q      <= 3'd0;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            flags_q    <= 3'b000;
            halted_q   <= 1'b0;
        end else begin
            if (state_q != HALT) begin
                flags_q <= flags_d;
            end
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (taken_w) begin
                        pc_q    <= br_target;
                        state_q <= FLUSH;
                        cnt_q   <= FLUSH_INIT;
                        flush_q <= 1'b1;
                    end else if (bus.halt) begin
                        state_q    <= HALT;
                        halted_q   <= 1'b1;
                        pc_valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        pc_q <= pc_plus2;
                    end
                end
                FLUSH: begin
                    if (taken_w) begin
                        pc_q    <= br_target;
                        cnt_q   <= FLUSH_INIT;
                        flush_q <= 1'b1;
                    end else begin
                        if (!bus.stall) begin
                            pc_q <= pc_plus2;
                        end
                        // Last flush cycle: drop flush together with the return to RUN
                        if (cnt_q <= 3'd1) begin
                            state_q <= RUN;
                            cnt_q   <= 3'd0;
                            flush_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.flush    = flush_q;
    assign bus.flags    = flags_q;
    assign bus.taken    = taken_w;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .FLUSH_CYCLES (2),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        valid;
        logic        vcare;
        logic        flush;
        logic [2:0]  flags;
        logic        halted;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] epc;
    logic [2:0]  eflags;
    logic [15:0] tgt;
    logic        exp_tk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] f);
        logic v, n, z;
        v = f[2];
        n = f[1];
        z = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic push_exp(input logic [15:0] pc, input logic valid, input logic vcare,
                            input logic flush, input logic halted);
        exp_t e;
        e.pc     = pc;
        e.valid  = valid;
        e.vcare  = vcare;
        e.flush  = flush;
        e.flags  = eflags;
        e.halted = halted;
        sb.push_back(e);
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".pc"}, bus.pc, e.pc);
        if (e.vcare) chk({tag, ".pc_valid"}, 16'(bus.pc_valid), 16'(e.valid));
        chk({tag, ".flush"}, 16'(bus.flush), 16'(e.flush));
        chk({tag, ".flags"}, 16'(bus.flags), 16'(e.flags));
        chk({tag, ".halted"}, 16'(bus.halted), 16'(e.halted));
    endtask

    task automatic step(input string tag, input logic [15:0] pc, input logic valid,
                        input logic vcare, input logic flush, input logic halted);
        push_exp(pc, valid, vcare, flush, halted);
        @(posedge clk);
        #1;
        compare_head(tag);
    endtask

    task automatic clear_inputs();
        bus.stall     = 1'b0;
        bus.halt      = 1'b0;
        bus.flag_wr   = 3'b000;
        bus.alu_flags = 3'b000;
        bus.br_valid  = 1'b0;
        bus.br_cond   = 3'b000;
        bus.br_reg    = 1'b0;
        bus.br_pc     = 16'h0000;
        bus.br_imm    = 9'h000;
        bus.br_tgt    = 16'h0000;
    endtask

    task automatic br_reg_drive(input logic [15:0] t, input logic [2:0] c);
        bus.br_valid = 1'b1;
        bus.br_reg   = 1'b1;
        bus.br_tgt   = t;
        bus.br_cond  = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n  = 1'b0;
        eflags = 3'b000;
        epc    = 16'h0000;
        #12;
        push_exp(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        compare_head("reset");
        bus.br_valid = 1'b1;
        bus.br_cond  = 3'b111;
        #1;
        chk("boot_taken", 16'(bus.taken), 16'd0);
        clear_inputs();

        // reset release: boot cycle then linear fetch
        rst_n = 1'b1;
        step("boot_exit", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step("run0", 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
        step("run1", 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0);

        // taken B with negative offset
        bus.br_valid = 1'b1;
        bus.br_reg   = 1'b0;
        bus.br_pc    = 16'h0010;
        bus.br_imm   = 9'h1FE;
        bus.br_cond  = 3'b111;
        #1;
        chk("b_taken", 16'(bus.taken), 16'd1);
        step("b_tgt", 16'h000E, 1'b1, 1'b1, 1'b1, 1'b0);
        clear_inputs();
        step("b_fl2", 16'h0010, 1'b1, 1'b1, 1'b1, 1'b0);
        step("b_run", 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0);
        step("b_run2", 16'h0014, 1'b1, 1'b1, 1'b0, 1'b0);
        epc = 16'h0014;

        // condition sweep: every code against every flag value
        for (int f = 0; f < 8; f++) begin
            bus.flag_wr   = 3'b111;
            bus.alu_flags = 3'(f);
            eflags        = 3'(f);
            epc           = epc + 16'd2;
            step($sformatf("flags_set f%0d", f), epc, 1'b1, 1'b1, 1'b0, 1'b0);
            bus.flag_wr = 3'b000;
            for (int c = 0; c < 8; c++) begin
                tgt = 16'h2000 + 16'(f * 64 + c * 8);
                br_reg_drive(tgt, 3'(c));
                #1;
                exp_tk = cond_ref(3'(c), 3'(f));
                chk($sformatf("sweep_taken c%0d f%0d", c, f), 16'(bus.taken), 16'(exp_tk));
                if (exp_tk) begin
                    epc = tgt;
                    step($sformatf("sweep_tgt c%0d f%0d", c, f), epc, 1'b1, 1'b1, 1'b1, 1'b0);
                    bus.br_valid = 1'b0;
                    epc = epc + 16'd2;
                    step("sweep_fl2", epc, 1'b1, 1'b1, 1'b1, 1'b0);
                    epc = epc + 16'd2;
                    step("sweep_run", epc, 1'b1, 1'b1, 1'b0, 1'b0);
                end else begin
                    epc = epc + 16'd2;
                    step($sformatf("sweep_nt c%0d f%0d", c, f), epc, 1'b1, 1'b1, 1'b0, 1'b0);
                    bus.br_valid = 1'b0;
                end
            end
        end

        // forwarding: Z written in the same cycle as an EQ branch
        bus.flag_wr   = 3'b111;
        bus.alu_flags = 3'b000;
        eflags        = 3'b000;
        epc           = epc + 16'd2;
        step("fwd_clear", epc, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.flag_wr   = 3'b001;
        bus.alu_flags = 3'b001;
        br_reg_drive(16'h1230, 3'b001);
        #1;
        eflags = 3'b001;
`ifdef PC_SEQ_FLAG_FWD_EN
        chk("fwd_taken", 16'(bus.taken), 16'd1);
        epc = 16'h1230;
        step("fwd_tgt", epc, 1'b1, 1'b1, 1'b1, 1'b0);
        clear_inputs();
        epc = epc + 16'd2;
        step("fwd_fl2", epc, 1'b1, 1'b1, 1'b1, 1'b0);
        epc = epc + 16'd2;
        step("fwd_run", epc, 1'b1, 1'b1, 1'b0, 1'b0);
`else
        chk("fwd_taken", 16'(bus.taken), 16'd0);
        epc = epc + 16'd2;
        step("fwd_nt", epc, 1'b1, 1'b1, 1'b0, 1'b0);
        clear_inputs();
`endif

        // independent per-bit flag writes: V set, N cleared (already 0), Z kept
        bus.flag_wr   = 3'b110;
        bus.alu_flags = 3'b100;
        eflags        = 3'b101;
        epc           = epc + 16'd2;
        step("flag_partial", epc, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.flag_wr = 3'b000;

        // branch beats halt and stall in the same cycle
        bus.stall = 1'b1;
        bus.halt  = 1'b1;
        br_reg_drive(16'h0100, 3'b111);
        #1;
        chk("prio_taken", 16'(bus.taken), 16'd1);
        epc = 16'h0100;
        step("prio_tgt", epc, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.br_valid = 1'b0;
        bus.stall    = 1'b0;
        epc = epc + 16'd2;
        step("flush_halt_ignored", epc, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.halt = 1'b0;
        epc = epc + 16'd2;
        step("prio_run", epc, 1'b1, 1'b1, 1'b0, 1'b0);

        // stall during flush holds PC while the counter keeps running
        br_reg_drive(16'h0400, 3'b111);
        epc = 16'h0400;
        step("sf_tgt", epc, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.br_valid = 1'b0;
        bus.stall    = 1'b1;
        step("sf_stall1", epc, 1'b1, 1'b1, 1'b1, 1'b0);
        step("sf_stall2", epc, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b0;
        epc = epc + 16'd2;
        step("sf_run", epc, 1'b1, 1'b1, 1'b0, 1'b0);

        // stall in RUN
        bus.stall = 1'b1;
        step("run_stall", epc, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b0;

        // halt parks the core; everything ignored afterwards
        bus.halt = 1'b1;
        step("halt_enter", epc, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            br_reg_drive(16'h5550, 3'b111);
            bus.flag_wr   = 3'b111;
            bus.alu_flags = 3'($urandom_range(0, 7));
            bus.stall     = 1'($urandom_range(0, 1));
            bus.halt      = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("halt_taken %0d", i), 16'(bus.taken), 16'd0);
            step($sformatf("halt_hold %0d", i), epc, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        clear_inputs();

        // async reset out of HALT
        rst_n = 1'b0;
        #1;
        eflags = 3'b000;
        push_exp(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        compare_head("halt_reset");
        rst_n = 1'b1;
        epc = 16'h0000;
        step("rst2_boot", epc, 1'b1, 1'b1, 1'b0, 1'b0);

        // wrap in RUN
        br_reg_drive(16'hFFFA, 3'b111);
        step("wr_tgt", 16'hFFFA, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.br_valid = 1'b0;
        step("wr_fl2", 16'hFFFC, 1'b1, 1'b1, 1'b1, 1'b0);
        step("wr_run", 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0);
        step("wr_wrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // B target wrap: FFFE + 2 + 0
        clear_inputs();
        bus.br_valid = 1'b1;
        bus.br_pc    = 16'hFFFE;
        bus.br_imm   = 9'h000;
        bus.br_cond  = 3'b111;
        #1;
        chk("bw_taken", 16'(bus.taken), 16'd1);
        step("bw_tgt", 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.br_valid = 1'b0;
        step("bw_fl2", 16'h0002, 1'b1, 1'b1, 1'b1, 1'b0);
        step("bw_run", 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0);

        // most negative offset: 0000 + 2 - 512
        bus.br_valid = 1'b1;
        bus.br_pc    = 16'h0000;
        bus.br_imm   = 9'h100;
        step("bn_tgt", 16'hFE02, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.br_valid = 1'b0;
        step("bn_fl2", 16'hFE04, 1'b1, 1'b1, 1'b1, 1'b0);
        step("bn_run", 16'hFE06, 1'b1, 1'b1, 1'b0, 1'b0);

        // wrap inside the flush window
        br_reg_drive(16'hFFFC, 3'b111);
        step("wf_tgt", 16'hFFFC, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.br_valid = 1'b0;
        step("wf_fl2", 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0);
        step("wf_run", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // reset asserted in FLUSH clears flush and PC without a clock edge
        br_reg_drive(16'h0300, 3'b111);
        step("mf_tgt", 16'h0300, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.br_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        push_exp(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        compare_head("mf_reset");
        rst_n = 1'b1;
        step("mf_boot", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mf_run", 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
